lbist_ctrl: RTL and testbench
=============================

// Module: lbist_ctrl
// PURPOSE
//   Logic-BIST sequencer for a technology-mapped gate-level circuit under test (CUT) built from
//   the library primitives (bufg/notg/and_n/.../pin/pout). Drives the CUT primary inputs with an
//   LFSR pattern stream and compacts the CUT primary outputs into a MISR. After N_PAT patterns it
//   compares the MISR signature with a golden value and reports pass/fail.
//   Sits between the test access logic (start/golden) and the CUT pin/pout boundary; test_mode_o
//   steers the functional/test input mux in front of the CUT.
// PARAMETERS
//   N_PI     16        CUT input width = LFSR width
//   N_PO     16        CUT output width = MISR width
//   N_PAT    256       patterns applied per run, >=1
//   CUT_LAT  1         cycles from pattern applied to response valid on cut_po_i, >=0
//   SEED     16'hACE1  LFSR load value; zero is illegal, so bit0 is forced to 1 on load
//   POLY     16'hB400  LFSR Galois tap mask (x^16+x^14+x^13+x^11+1)
//   MPOLY    16'hB400  MISR Galois tap mask
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active high
//   start_i    in   1      run request; sampled only in IDLE
//   golden_i   in   N_PO   expected signature; sampled in COMPARE
//   cut_po_i   in   N_PO   CUT primary outputs
//   cut_pi_o   out  N_PI   pattern to CUT primary inputs
//   test_mode_o out 1      1 = CUT inputs driven from cut_pi_o
//   busy_o     out  1      high from RUN through COMPARE
//   done_o     out  1      one-cycle pulse in DONE
//   pass_o     out  1      result, held until the next start is accepted
// BEHAVIOUR
//   Reset: state=IDLE, lfsr=0, misr=0, cnt=0, valid pipe=0; every output is 0.
//   FSM states: IDLE -> RUN -> FLUSH -> COMPARE -> DONE -> IDLE.
//   IDLE:    start_i=1 -> RUN. Load lfsr=SEED|1, clear misr, cnt and pass_o.
//   RUN:     cut_pi_o=lfsr. Each cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0), cnt++.
//            The cycle with cnt==N_PAT-1 is the last pattern -> FLUSH (or COMPARE if CUT_LAT=0).
//   Valid pipe: CUT_LAT-deep shift register. Input is 1 in RUN, otherwise 0. Output vld
//            (vld = the RUN flag itself when CUT_LAT=0). When vld=1:
//            misr <= ((misr>>1) ^ (misr[0] ? MPOLY : 0)) ^ cut_po_i.
//            Exactly N_PAT responses are compacted; the first is captured CUT_LAT cycles after the
//            first pattern.
//   FLUSH:   lasts CUT_LAT cycles. lfsr and cnt hold; cut_pi_o holds the last pattern; capture
//            continues.
//   COMPARE: one cycle; pass_o <= (misr == golden_i).
//   DONE:    done_o=1, busy_o=0 for one cycle -> IDLE. pass_o stays valid.
//   Latency: done_o is high exactly N_PAT+CUT_LAT+2 cycles after the edge that accepted start_i.
//   test_mode_o=1 in RUN/FLUSH/COMPARE. In IDLE/DONE, test_mode_o=0 and cut_pi_o=0.
//   Counter width is $clog2(N_PAT+1). The LFSR never reaches 0; wrap-around within its period
//   is legal.
//   start_i is ignored in every non-IDLE state, including DONE; no queuing.
//   rst asserted mid-run aborts at once: all state and outputs return to reset values.
//   No partial result is reported.
// CONFIGURATION
//   LBIST_SIG_OUT_EN defined: adds port sig_o (out, N_PO) = misr register.
//     sig_o is continuously visible; it is final from COMPARE until the next start. It is
//     cleared by rst and by start acceptance.
//   Undefined: no sig_o port and no extra logic; only the pass/fail result is observable.
// TESTING  (unless noted: N_PI=N_PO=4, POLY=MPOLY=4'hC, SEED=4'h1, CUT_LAT=1)
//   1 rst=1 at any time -> next sample: cut_pi_o=0, busy_o=0, done_o=0, pass_o=0,
//     test_mode_o=0.
//   2 start_i pulse -> RUN-cycle cut_pi_o sequence 1,C,6,3,D; busy_o=1 from the cycle after start.
//   3 Bench loopback CUT (cut_po_i = cut_pi_o delayed 1 cycle), N_PAT=15, golden from a model
//     -> done_o pulses exactly 18 cycles after start; pass_o=1.
//   4 As test 3, with cut_po_i[0] inverted for the 7th response only -> pass_o=0, done_o timing
//     unchanged.
//   5 rst during 5th pattern, then start again -> busy_o=0 immediately; the new run begins at
//     cut_pi_o=1 and passes.
//   6 start_i held high through a whole run plus DONE -> only one run; the next run starts
//     2 cycles after DONE? No: a new run is accepted in the first IDLE cycle only, pass_o
//     is held through DONE, and with LBIST_SIG_OUT_EN, sig_o==golden_i after COMPARE.

Source files
------------

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: LFSR pattern source, MISR response compactor, golden signature compare.
// Optional feature macro LBIST_SIG_OUT_EN adds the sig_o port carrying the live MISR value.
//
// state   | meaning
// IDLE    | waiting for start_i; outputs parked at 0
// RUN     | one LFSR pattern per cycle on cut_pi_o, N_PAT cycles
// FLUSH   | CUT_LAT cycles draining in-flight responses into the MISR
// COMPARE | MISR checked against golden_i
// DONE    | one-cycle done_o pulse, result on pass_o
module lbist_ctrl #(
    parameter int              N_PI    = 16,
    parameter int              N_PO    = 16,
    parameter int              N_PAT   = 256,
    parameter int              CUT_LAT = 1,
    parameter logic [N_PI-1:0] SEED    = 16'hACE1,
    parameter logic [N_PI-1:0] POLY    = 16'hB400,
    parameter logic [N_PO-1:0] MPOLY   = 16'hB400
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [N_PO-1:0] golden_i,
    input  logic [N_PO-1:0] cut_po_i,
    output logic [N_PI-1:0] cut_pi_o,
    output logic            test_mode_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o
`ifdef LBIST_SIG_OUT_EN
    ,
    output logic [N_PO-1:0] sig_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int              CW         = $clog2(N_PAT + 1);
    localparam int              FW         = (CUT_LAT > 1) ? $clog2(CUT_LAT) : 1;
    localparam logic [CW-1:0]   LAST_CNT   = CW'(N_PAT - 1);
    localparam logic [FW-1:0]   FLUSH_LOAD = FW'((CUT_LAT > 0) ? (CUT_LAT - 1) : 0);
    localparam logic [N_PI-1:0] SEED_LOAD  = SEED | N_PI'(1);

    state_t          state_q, state_d;
    logic [N_PI-1:0] lfsr_q, lfsr_d;
    logic [N_PO-1:0] misr_q, misr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic            pass_q, pass_d;
    logic            run_flag;
    logic            vld;

    function automatic logic [N_PI-1:0] lfsr_step(input logic [N_PI-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

    function automatic logic [N_PO-1:0] misr_step(input logic [N_PO-1:0] v,
                                                  input logic [N_PO-1:0] din);
        return ((v >> 1) ^ (v[0] ? MPOLY : '0)) ^ din;
    endfunction

    // Response-valid tracker: a RUN flag delayed by the CUT latency marks capture cycles.
    generate
        if (CUT_LAT == 0) begin : g_no_pipe
            assign vld = run_flag;
        end else begin : g_pipe
            logic [CUT_LAT-1:0] vld_pipe_q, vld_pipe_d;

            always_comb begin
                vld_pipe_d = vld_pipe_q;
                for (int i = CUT_LAT - 1; i > 0; i--) begin
                    vld_pipe_d[i] = vld_pipe_q[i-1];
                end
                vld_pipe_d[0] = run_flag;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe_q <= '0;
                end else begin
                    vld_pipe_q <= vld_pipe_d;
                end
            end

            assign vld = vld_pipe_q[CUT_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        pass_d   = pass_q;
        run_flag = 1'b0;

        if (vld) begin
            misr_d = misr_step(misr_q, cut_po_i);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    lfsr_d  = SEED_LOAD;
                    misr_d  = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                run_flag = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // The LFSR is not stepped on the last pattern so FLUSH keeps presenting it.
                if (cnt_q == LAST_CNT) begin
                    if (CUT_LAT == 0) begin
                        state_d = S_COMPARE;
                    end else begin
                        state_d = S_FLUSH;
                        flush_d = FLUSH_LOAD;
                    end
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            S_FLUSH: begin
                if (flush_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            S_COMPARE: begin
                pass_d  = (misr_q == golden_i);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            pass_q  <= pass_d;
        end
    end

    assign test_mode_o = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_COMPARE);
    assign busy_o      = test_mode_o;
    assign cut_pi_o    = test_mode_o ? lfsr_q : '0;
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = pass_q;

`ifdef LBIST_SIG_OUT_EN
    assign sig_o = misr_q;
`endif

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: table-driven loopback runs, reset/start corner sequences, random responses.
module tb_lbist_ctrl;

    localparam int         NP      = 15;
    localparam int         LAT     = 1;
    localparam int         DONE_AT = NP + LAT + 2;
    localparam logic [3:0] SEED    = 4'h1;
    localparam logic [3:0] POLY    = 4'hC;
    localparam logic [3:0] MPOLY   = 4'hC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] golden_i;
    logic [3:0] cut_po_i;
    logic [3:0] cut_pi_o;
    logic       test_mode_o;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
`ifdef LBIST_SIG_OUT_EN
    logic [3:0] sig_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] pat [NP];
    logic [3:0] clean_sig;
    logic [3:0] seq_hand [5];

    typedef struct {
        string      name;
        int         fault_k;
        logic [3:0] gxor;
        int         exp_pass;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    lbist_ctrl #(
        .N_PI(4), .N_PO(4), .N_PAT(NP), .CUT_LAT(LAT),
        .SEED(SEED), .POLY(POLY), .MPOLY(MPOLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .golden_i(golden_i),
        .cut_po_i(cut_po_i),
        .cut_pi_o(cut_pi_o),
        .test_mode_o(test_mode_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .pass_o(pass_o)
`ifdef LBIST_SIG_OUT_EN
        ,
        .sig_o(sig_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Galois step as division by x modulo the tap polynomial, written arithmetically.
    function automatic logic [3:0] gstep(input logic [3:0] v, input logic [3:0] taps);
        int q;
        q = int'(v) / 2;
        return 4'(q) ^ ((int'(v) % 2 == 1) ? taps : 4'h0);
    endfunction

    task automatic check_idle_outputs(input string name);
        chk({name, ":cut_pi"}, cut_pi_o, 0);
        chk({name, ":busy"}, busy_o, 0);
        chk({name, ":done"}, done_o, 0);
        chk({name, ":pass"}, pass_o, 0);
        chk({name, ":test_mode"}, test_mode_o, 0);
    endtask

    // One full run starting at a negedge with the DUT in IDLE. cycle k=0 is the start cycle.
    // exp_tbl < 0 means the expected pass comes from the response model.
    task automatic run_check(input string name, input bit rnd, input int fault_k,
                             input logic [3:0] gxor, input int exp_tbl, input bit hold_start);
        logic [3:0] prev_pi;
        logic [3:0] sig;
        logic [3:0] gold;
        bit         exp_pass;
        int         done_k;
        prev_pi  = 4'h0;
        sig      = 4'h0;
        exp_pass = 1'b0;
        done_k   = -1;
        start_i  = 1'b1;
        cut_po_i = 4'h0;
        golden_i = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start_i = 1'b0;
        for (int k = 1; k <= DONE_AT + 4 && done_k < 0; k++) begin
            if (k <= NP) chk({name, ":pattern"}, cut_pi_o, pat[k-1]);
            if (k <= 5) chk({name, ":pattern_hand"}, cut_pi_o, seq_hand[k-1]);
            if (k == NP + 1) chk({name, ":flush_hold"}, cut_pi_o, pat[NP-1]);
            if (k < DONE_AT) begin
                chk({name, ":busy"}, busy_o, 1);
                chk({name, ":test_mode"}, test_mode_o, 1);
                chk({name, ":early_done"}, done_o, 0);
            end
            if (done_o) begin
                done_k = k;
                chk({name, ":done_at"}, k, DONE_AT);
                chk({name, ":pass"}, pass_o, exp_pass);
                chk({name, ":busy_in_done"}, busy_o, 0);
                chk({name, ":tm_in_done"}, test_mode_o, 0);
                chk({name, ":pi_in_done"}, cut_pi_o, 0);
`ifdef LBIST_SIG_OUT_EN
                chk({name, ":sig"}, sig_o, sig);
`endif
            end
            cut_po_i = rnd ? 4'($urandom) : prev_pi;
            if (k == fault_k) cut_po_i[0] = ~cut_po_i[0];
            prev_pi = cut_pi_o;
            if (k >= 1 + LAT && k <= NP + LAT) sig = gstep(sig, MPOLY) ^ cut_po_i;
            if (k == NP + LAT + 1) begin
                gold     = (rnd ? sig : clean_sig) ^ gxor;
                golden_i = gold;
                exp_pass = (exp_tbl < 0) ? (sig == gold) : (exp_tbl != 0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (done_k < 0) chk({name, ":done_timeout"}, 1, 0);
        chk({name, ":done_once"}, done_o, 0);
        chk({name, ":pass_held"}, pass_o, exp_pass);
        chk({name, ":busy_idle"}, busy_o, 0);
        chk({name, ":pi_idle"}, cut_pi_o, 0);
        if (hold_start) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, ":restart_busy"}, busy_o, 1);
            chk({name, ":restart_pass_clr"}, pass_o, 0);
            chk({name, ":restart_pi"}, cut_pi_o, seq_hand[0]);
`ifdef LBIST_SIG_OUT_EN
            chk({name, ":restart_sig_clr"}, sig_o, 0);
`endif
            start_i = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v;
        rst      = 1'b1;
        start_i  = 1'b0;
        golden_i = 4'h0;
        cut_po_i = 4'h0;

        seq_hand = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD};
        v = SEED | 4'h1;
        clean_sig = 4'h0;
        for (int i = 0; i < NP; i++) begin
            pat[i]    = v;
            clean_sig = gstep(clean_sig, MPOLY) ^ v;
            v         = gstep(v, POLY);
        end

        tbl[0] = '{"clean",       -1, 4'h0, 1};
        tbl[1] = '{"fault_7th",    8, 4'h0, 0};
        tbl[2] = '{"bad_golden",  -1, 4'h8, 0};
        tbl[3] = '{"fault_first",  2, 4'h0, 0};
        tbl[4] = '{"fault_last",  16, 4'h0, 0};

        #2;
        check_idle_outputs("reset");
`ifdef LBIST_SIG_OUT_EN
        chk("reset:sig", sig_o, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");

        for (int i = 0; i < 5; i++) begin
            run_check(tbl[i].name, 1'b0, tbl[i].fault_k, tbl[i].gxor, tbl[i].exp_pass, 1'b0);
        end

        // Abort during the 5th pattern, then a fresh run must start from the seed and pass.
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort:pattern5", cut_pi_o, pat[4]);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("abort");
`ifdef LBIST_SIG_OUT_EN
        chk("abort:sig", sig_o, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_check("after_abort", 1'b0, -1, 4'h0, 1, 1'b0);

        run_check("start_held", 1'b0, -1, 4'h0, 1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            logic [3:0] gx;
            gx = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_check($sformatf("random%0d", r), 1'b1, -1, gx, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
